// File: rtl/sd_converter_multi.sv
// rtl/sd_converter_multi.sv - multi-channel stochastic bitstream to count/bipolar value converter
module sd_converter_multi #(
  parameter int NCH     = 2,
  parameter int LEN     = 256,
  parameter int BIPOLAR = 0,
  parameter int W       = $clog2(NCH*LEN+1) + BIPOLAR
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [NCH-1:0] bits,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           frame_busy
);

  // Accumulator is sized for the largest frame sum, so it never wraps.
  localparam int AW = $clog2(NCH*LEN+1);
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int PW = $clog2(NCH+1);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(LEN-1);
  localparam logic [W-1:0]  FULL_SCALE = W'(NCH*LEN);

  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_beat_cnt;
  logic [W-1:0]  r_out_data;
  logic          r_out_valid;

  logic [PW-1:0] w_pop;
  logic [AW-1:0] w_sum;
  logic [W-1:0]  w_result;
  logic          w_last;
  logic          w_accept;
  logic          w_final;

  // Number of ones across all channels in the current beat
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NCH; i++) begin
      w_pop = w_pop + PW'(bits[i]);
    end
  end

  assign w_sum    = r_acc + AW'(w_pop);
  assign w_last   = (r_beat_cnt == LAST_BEAT);

  // Only the final beat can be blocked, and only when it would overwrite an unread result.
  assign in_ready = !(w_last && r_out_valid && !out_ready);
  assign w_accept = in_valid && in_ready && !clear;
  assign w_final  = w_accept && w_last;

  // Bipolar maps S in 0..N to 2S-N; the extra output bit carries the sign.
  generate
    if (BIPOLAR != 0) begin : g_bipolar
      assign w_result = {w_sum, 1'b0} - FULL_SCALE;
    end else begin : g_unipolar
      assign w_result = W'(w_sum);
    end
  endgenerate

  // Frame accumulator and beat counter; the final beat restarts the frame on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_beat_cnt <= '0;
    end else if (clear) begin
      r_acc      <= '0;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc      <= '0;
        r_beat_cnt <= '0;
      end else begin
        r_acc      <= w_sum;
        r_beat_cnt <= r_beat_cnt + CW'(1);
      end
    end
  end

  // Output holding register; a new result may replace one being consumed on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_final) begin
      r_out_data  <= w_result;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign frame_busy = (r_beat_cnt != '0);

endmodule

// File: tb/tb_sd_converter_multi.sv
// tb/tb_sd_converter_multi.sv - bench for sd_converter_multi, unipolar and bipolar instances
module tb_sd_converter_multi;

  localparam int NCH = 2;
  localparam int LEN = 4;
  localparam int WU  = 4;
  localparam int WB  = 5;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic [1:0]    bits;
  logic          out_ready;
  logic          in_ready_u, in_ready_b;
  logic [WU-1:0] out_data_u;
  logic [WB-1:0] out_data_b;
  logic          out_valid_u, out_valid_b;
  logic          frame_busy_u, frame_busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  sd_converter_multi #(.NCH(NCH), .LEN(LEN), .BIPOLAR(0)) u_uni (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_u),
    .bits(bits), .out_data(out_data_u), .out_valid(out_valid_u), .out_ready(out_ready),
    .frame_busy(frame_busy_u)
  );

  sd_converter_multi #(.NCH(NCH), .LEN(LEN), .BIPOLAR(1)) u_bip (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .bits(bits), .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .frame_busy(frame_busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: beats of the open frame kept as a list of popcounts
  int m_q[$];
  bit m_ov = 1'b0;
  int m_du = 0;
  int m_db = 0;

  function automatic bit model_ready();
    return !((m_q.size() == LEN-1) && m_ov && !out_ready);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge and compare DUT state with the model
  task automatic apply(input logic rst, input logic clr, input logic iv,
                       input logic [1:0] b, input logic ordy);
    @(negedge clk);
    reset = rst; clear = clr; in_valid = iv; bits = b; out_ready = ordy;
    #1;
    chk("m_in_ready_u", int'(in_ready_u), int'(model_ready()));
    chk("m_in_ready_b", int'(in_ready_b), int'(model_ready()));
    chk("m_out_valid_u", int'(out_valid_u), int'(m_ov));
    chk("m_out_valid_b", int'(out_valid_b), int'(m_ov));
    chk("m_out_data_u", int'(out_data_u), m_du);
    chk("m_out_data_b", int'($signed(out_data_b)), m_db);
    chk("m_frame_busy_u", int'(frame_busy_u), int'(m_q.size() != 0));
    chk("m_frame_busy_b", int'(frame_busy_b), int'(m_q.size() != 0));
  endtask

  // Advance one rising edge and update the model from the inputs held across it
  task automatic commit();
    bit acc;
    bit load;
    int s;
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_ov = 1'b0;
      m_du = 0;
      m_db = 0;
    end else begin
      acc  = in_valid && model_ready() && !clear;
      load = 1'b0;
      if (clear) begin
        m_q.delete();
      end else if (acc) begin
        m_q.push_back($countones(bits));
        if (m_q.size() == LEN) begin
          s    = m_q.sum();
          m_du = s;
          m_db = 2*s - NCH*LEN;
          load = 1'b1;
          m_q.delete();
        end
      end
      if (load) m_ov = 1'b1;
      else if (m_ov && out_ready) m_ov = 1'b0;
    end
  endtask

  task automatic drv(input logic rst, input logic clr, input logic iv,
                     input logic [1:0] b, input logic ordy);
    apply(rst, clr, iv, b, ordy);
    commit();
  endtask

  typedef struct {
    logic       rst;
    logic       clr;
    logic       iv;
    logic [1:0] b;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    int         e_d;
    logic       e_fb;
  } vec_t;

  vec_t tbl [15];

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; bits = 2'b00; out_ready = 1'b1;

    // Back-to-back frames, then a stalled final beat released by one out_ready cycle
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 8, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 5, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 5, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 5, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 5, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 5, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 8, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8, 1'b0};

    drv(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    drv(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].rst, tbl[i].clr, tbl[i].iv, tbl[i].b, tbl[i].ordy);
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready_u), int'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid_u), int'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_data", i), int'(out_data_u), tbl[i].e_d);
      chk($sformatf("tbl%0d_frame_busy", i), int'(frame_busy_u), int'(tbl[i].e_fb));
      commit();
    end

    // Bipolar extremes: all zeros gives -N, balanced stream gives 0
    for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
    #2;
    chk("bip_all_zero", int'($signed(out_data_b)), -8);
    chk("bip_all_zero_raw", int'(out_data_b), 24);
    chk("uni_all_zero", int'(out_data_u), 0);
    for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
    #2;
    chk("bip_balanced", int'($signed(out_data_b)), 0);
    chk("uni_balanced", int'(out_data_u), 4);

    // Clear mid-frame drops the presented beat and keeps the previous result
    for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
    drv(1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
    drv(1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
    drv(1'b0, 1'b1, 1'b1, 2'b11, 1'b1);
    #2;
    chk("clear_frame_busy", int'(frame_busy_u), 0);
    chk("clear_keeps_data", int'(out_data_u), 8);
    for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 1'b1, 2'b01, 1'b1);
    #2;
    chk("after_clear_data", int'(out_data_u), 4);
    chk("after_clear_valid", int'(out_valid_u), 1);

    // Reset with a pending result and a partial frame
    for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 3; i++) drv(1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    drv(1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    #2;
    chk("rst_out_valid", int'(out_valid_u), 0);
    chk("rst_out_data", int'(out_data_u), 0);
    chk("rst_out_data_b", int'(out_data_b), 0);
    chk("rst_frame_busy", int'(frame_busy_u), 0);
    apply(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("rst_in_ready", int'(in_ready_u), 1);
    commit();
    for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
    #2;
    chk("post_rst_data", int'(out_data_u), 8);

    // Gapped input: completion counts accepted beats, not cycles
    drv(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    for (int k = 0; k < 7; k++) begin
      drv(1'b0, 1'b0, (k % 2 == 0), 2'b10, 1'b1);
      #2;
      if (k == 5) chk("gap_not_yet_valid", int'(out_valid_u), 0);
    end
    chk("gap_valid", int'(out_valid_u), 1);
    chk("gap_data", int'(out_data_u), 4);
    chk("gap_data_b", int'($signed(out_data_b)), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drv(($urandom % 400) == 0, ($urandom % 30) == 0, ($urandom % 4) != 0,
          2'($urandom), ($urandom % 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
